// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges load and ALU results into one register-file write per cycle
// Loads always win; ALU results wait in a small FIFO or bypass it when it is empty.
module writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                   inp_clk,
    input  logic                   inp_rst,
    input  logic                   inp_alu_valid,
    input  logic                   inp_alu_wen,
    input  logic [ADDR_W-1:0]      inp_alu_rd,
    input  logic [DATA_W-1:0]      inp_alu_data,
    output logic                   out_alu_ready,
    input  logic                   inp_ld_valid,
    input  logic [ADDR_W-1:0]      inp_ld_rd,
    input  logic [DATA_W-1:0]      inp_ld_data,
    input  logic                   inp_issue_valid,
    input  logic [ADDR_W-1:0]      inp_issue_rd,
    output logic [DATA_W-1:0]      out_dataWrite,
    output logic [ADDR_W-1:0]      out_regWrite,
    output logic                   out_flagWrite,
    output logic [(1<<ADDR_W)-1:0] out_pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_alu_ready;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_rd;
    logic              r_flag;
    logic [NREG-1:0]   r_pending;

    logic              w_accept;
    logic              w_acc_wr;
    logic              w_empty;
    logic              w_sel_ld;
    logic              w_sel_pop;
    logic              w_sel_byp;
    logic              w_push;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_rd;
    logic [DATA_W-1:0] w_wr_data;
    logic [CNT_W-1:0]  w_count_next;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;

    assign w_accept  = inp_alu_valid & r_alu_ready;
    assign w_acc_wr  = w_accept & inp_alu_wen;
    assign w_empty   = (r_count == '0);
    assign w_sel_ld  = inp_ld_valid;
    assign w_sel_pop = !inp_ld_valid && !w_empty;
    assign w_sel_byp = !inp_ld_valid && w_empty && w_acc_wr;
    assign w_push    = w_acc_wr && !w_sel_byp;
    assign w_wr_en   = w_sel_ld | w_sel_pop | w_sel_byp;

    always_comb begin
        w_wr_rd   = inp_alu_rd;
        w_wr_data = inp_alu_data;
        if (w_sel_ld) begin
            w_wr_rd   = inp_ld_rd;
            w_wr_data = inp_ld_data;
        end else if (w_sel_pop) begin
            w_wr_rd   = r_mem_rd[r_rd_ptr];
            w_wr_data = r_mem_data[r_rd_ptr];
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_sel_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_sel_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit outstanding.
    assign w_set_mask = inp_issue_valid ? (NREG'(1) << inp_issue_rd) : '0;
    assign w_clr_mask = w_wr_en ? (NREG'(1) << w_wr_rd) : '0;

    always_ff @(posedge inp_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= inp_alu_data;
            r_mem_rd[r_wr_ptr]   <= inp_alu_rd;
        end
    end

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_alu_ready <= 1'b1;
            r_data      <= '0;
            r_rd        <= '0;
            r_flag      <= 1'b0;
            r_pending   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_sel_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_alu_ready <= (w_count_next != CNT_W'(DEPTH));
            r_flag      <= w_wr_en;
            if (w_wr_en) begin
                r_data <= w_wr_data;
                r_rd   <= w_wr_rd;
            end
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign out_alu_ready = r_alu_ready;
    assign out_dataWrite = r_data;
    assign out_regWrite  = r_rd;
    assign out_flagWrite = r_flag;
    assign out_pending   = r_pending;
endmodule
